// File: rtl/bcd_display_driver.sv
// Two-digit BCD to active-low 7-segment driver with rollover detect and sticky digit error.
// Define BCD_DISPLAY_BLINK_EN to compile in the post-rollover blink sequence.
module bcd_display_driver #(
    parameter int BLINK_HALF_PERIOD = 25000000,
    parameter int BLINK_COUNT       = 3,
    parameter int LZ_BLANK          = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] count,
    input  logic [3:0] count_tens,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic       rollover,
    output logic       digit_err,
    output logic       blink_active
);

    localparam logic [6:0] SegBlank  = 7'h7F;
    localparam logic [6:0] SegZero   = 7'h40;
    localparam logic [6:0] Hex1Reset = (LZ_BLANK != 0) ? SegBlank : SegZero;

    function automatic logic [6:0] decodeDigit(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h06;
        endcase
        return seg;
    endfunction

    // Reset asserts asynchronously but every other register leaves reset on the same edge.
    logic [1:0] rstSync_q;
    logic       rstN;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rstSync_q <= 2'b00;
        else          rstSync_q <= {rstSync_q[0], 1'b1};
    end

    assign rstN = rstSync_q[1];

    logic [3:0] ones_q, tens_q;
    logic       s1Valid_q;

    always_ff @(posedge clock or negedge rstN) begin
        if (!rstN) begin
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            s1Valid_q <= 1'b0;
        end else begin
            ones_q    <= count;
            tens_q    <= count_tens;
            s1Valid_q <= 1'b1;
        end
    end

    logic [6:0] hex0_d, hex1_d, hex0_q, hex1_q;
    logic       rollover_d, rollover_q, digitErr_d, digitErr_q;
    logic [3:0] prevOnes_q, prevTens_q;
    logic       prevValid_q;

    // prevValid_q keeps the reset value of stage 1 from counting as a 99 sample.
    always_comb begin
        hex0_d     = decodeDigit(ones_q);
        hex1_d     = ((LZ_BLANK != 0) && (tens_q == 4'd0)) ? SegBlank : decodeDigit(tens_q);
        rollover_d = prevValid_q && (prevOnes_q == 4'd9) && (prevTens_q == 4'd9)
                     && (ones_q == 4'd0) && (tens_q == 4'd0);
        digitErr_d = digitErr_q || (ones_q > 4'd9) || (tens_q > 4'd9);
    end

    always_ff @(posedge clock or negedge rstN) begin
        if (!rstN) begin
            hex0_q      <= SegZero;
            hex1_q      <= Hex1Reset;
            rollover_q  <= 1'b0;
            digitErr_q  <= 1'b0;
            prevOnes_q  <= 4'd0;
            prevTens_q  <= 4'd0;
            prevValid_q <= 1'b0;
        end else begin
            hex0_q      <= hex0_d;
            hex1_q      <= hex1_d;
            rollover_q  <= rollover_d;
            digitErr_q  <= digitErr_d;
            prevOnes_q  <= ones_q;
            prevTens_q  <= tens_q;
            prevValid_q <= s1Valid_q;
        end
    end

    logic blank;

`ifdef BCD_DISPLAY_BLINK_EN
    typedef enum logic [1:0] {IDLE, ON, OFF} blinkState_t;

    localparam int HalfW  = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam int CountW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
    localparam logic [HalfW-1:0]  HalfLast  = HalfW'(BLINK_HALF_PERIOD - 1);
    localparam logic [CountW-1:0] CountLast = CountW'(BLINK_COUNT - 1);

    blinkState_t       state_d, state_q;
    logic [HalfW-1:0]  halfCnt_d, halfCnt_q;
    logic [CountW-1:0] blinkCnt_d, blinkCnt_q;

    // A rollover always wins, so a new 99->00 restarts the sequence from a fresh ON phase.
    always_comb begin
        state_d    = state_q;
        halfCnt_d  = halfCnt_q;
        blinkCnt_d = blinkCnt_q;
        if (rollover_q) begin
            state_d    = ON;
            halfCnt_d  = '0;
            blinkCnt_d = '0;
        end else begin
            case (state_q)
                ON: begin
                    if (halfCnt_q == HalfLast) begin
                        state_d   = OFF;
                        halfCnt_d = '0;
                    end else begin
                        halfCnt_d = halfCnt_q + 1'b1;
                    end
                end
                OFF: begin
                    if (halfCnt_q == HalfLast) begin
                        halfCnt_d = '0;
                        if (blinkCnt_q == CountLast) begin
                            state_d    = IDLE;
                            blinkCnt_d = '0;
                        end else begin
                            state_d    = ON;
                            blinkCnt_d = blinkCnt_q + 1'b1;
                        end
                    end else begin
                        halfCnt_d = halfCnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            halfCnt_q  <= '0;
            blinkCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            halfCnt_q  <= halfCnt_d;
            blinkCnt_q <= blinkCnt_d;
        end
    end

    assign blank        = (state_q == OFF);
    assign blink_active = (state_q != IDLE);
`else
    assign blank        = 1'b0;
    assign blink_active = 1'b0;
`endif

    assign hex0      = blank ? SegBlank : hex0_q;
    assign hex1      = blank ? SegBlank : hex1_q;
    assign rollover  = rollover_q;
    assign digit_err = digitErr_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench for bcd_display_driver: a sample-history reference model queues expected
// outputs per input sample, and a monitor pops them as the pipelined outputs appear.
module tb_bcd_display_driver;

    localparam int HALF   = 4;
    localparam int BLINKS = 3;
    localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        logic [6:0] hex0;
        logic [6:0] hex1;
        logic [6:0] hex1Nlz;
        logic       rollover;
        logic       digitErr;
        logic       blinkActive;
    } expect_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] count = 4'd0;
    logic [3:0] countTens = 4'd0;
    logic [6:0] hex0, hex1, hex0Nlz, hex1Nlz;
    logic       rollover, digitErr, blinkActive;
    logic       rolloverNlz, digitErrNlz, blinkActiveNlz;

    int checks = 0;
    int failures = 0;

    expect_t sbq[$];
    expect_t mon;
    bit      monitorEnable = 1'b0;

    int prevOnes, prevTens, sampleIdx, lastRoll;
    bit prevValid, errSeen, blinkOn;

    bcd_display_driver #(
        .BLINK_HALF_PERIOD(HALF), .BLINK_COUNT(BLINKS), .LZ_BLANK(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .count(count), .count_tens(countTens),
        .hex0(hex0), .hex1(hex1), .rollover(rollover), .digit_err(digitErr),
        .blink_active(blinkActive)
    );

    bcd_display_driver #(
        .BLINK_HALF_PERIOD(HALF), .BLINK_COUNT(BLINKS), .LZ_BLANK(0)
    ) dutNlz (
        .clock(clock), .reset_n(reset_n), .count(count), .count_tens(countTens),
        .hex0(hex0Nlz), .hex1(hex1Nlz), .rollover(rolloverNlz), .digit_err(digitErrNlz),
        .blink_active(blinkActiveNlz)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] segOf(input int d);
        if (d > 9) return 7'h06;
        return SEG[d];
    endfunction

    task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, actual, expected, $time);
        end
    endtask

    // Expected outputs come from the input history: last 99->00 sample index drives the blink phase.
    task automatic applyStimulus(input int ones, input int tens);
        expect_t e;
        int      d;
        bit      blankNow;
        @(negedge clock);
        count     = ones[3:0];
        countTens = tens[3:0];
        e.rollover = prevValid && prevOnes == 9 && prevTens == 9 && ones == 0 && tens == 0;
        errSeen    = errSeen || ones > 9 || tens > 9;
        e.digitErr = errSeen;
        d = sampleIdx - lastRoll;
        e.blinkActive = blinkOn && d >= 1 && d <= 2 * HALF * BLINKS;
        blankNow      = e.blinkActive && (((d - 1) / HALF) % 2 == 1);
        e.hex0    = blankNow ? 7'h7F : segOf(ones);
        e.hex1    = blankNow ? 7'h7F : (tens == 0 ? 7'h7F : segOf(tens));
        e.hex1Nlz = blankNow ? 7'h7F : segOf(tens);
        if (e.rollover) lastRoll = sampleIdx;
        prevOnes  = ones;
        prevTens  = tens;
        prevValid = 1'b1;
        sampleIdx++;
        sbq.push_back(e);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_hex0"}, hex0, 7'h40);
        checkOutput({tag, "_hex1"}, hex1, 7'h7F);
        checkOutput({tag, "_hex1_nolz"}, hex1Nlz, 7'h40);
        checkOutput({tag, "_rollover"}, {6'd0, rollover}, 7'd0);
        checkOutput({tag, "_digit_err"}, {6'd0, digitErr}, 7'd0);
        checkOutput({tag, "_blink_active"}, {6'd0, blinkActive}, 7'd0);
        checkOutput({tag, "_blink_active_nolz"}, {6'd0, blinkActiveNlz}, 7'd0);
    endtask

    task automatic applyReset();
        monitorEnable = 1'b0;
        @(negedge clock);
        reset_n   = 1'b0;
        count     = 4'd0;
        countTens = 4'd0;
        #1;
        checkResetValues("reset_async");
        sbq.delete();
        repeat (2) @(negedge clock);
        checkResetValues("reset_held");
        reset_n = 1'b1;
        @(negedge clock);
        prevValid = 1'b0;
        errSeen   = 1'b0;
        sampleIdx = 0;
        lastRoll  = -1000000;
        monitorEnable = 1'b1;
    endtask

    // Two queued entries means the oldest one's sample has reached the hex registers.
    initial begin
        forever begin
            @(posedge clock);
            #3;
            if (monitorEnable && sbq.size() >= 2) begin
                mon = sbq.pop_front();
                checkOutput("hex0", hex0, mon.hex0);
                checkOutput("hex1", hex1, mon.hex1);
                checkOutput("rollover", {6'd0, rollover}, {6'd0, mon.rollover});
                checkOutput("digit_err", {6'd0, digitErr}, {6'd0, mon.digitErr});
                checkOutput("blink_active", {6'd0, blinkActive}, {6'd0, mon.blinkActive});
                checkOutput("hex0_nolz", hex0Nlz, mon.hex0);
                checkOutput("hex1_nolz", hex1Nlz, mon.hex1Nlz);
                checkOutput("rollover_nolz", {6'd0, rolloverNlz}, {6'd0, mon.rollover});
                checkOutput("digit_err_nolz", {6'd0, digitErrNlz}, {6'd0, mon.digitErr});
            end
        end
    end

    initial begin
`ifdef BCD_DISPLAY_BLINK_EN
        blinkOn = 1'b1;
`else
        blinkOn = 1'b0;
`endif
        applyReset();

        repeat (3) applyStimulus(7, 4);
        repeat (3) applyStimulus(5, 0);
        applyStimulus(8, 9);
        applyStimulus(9, 9);
        applyStimulus(0, 0);
        repeat (2) applyStimulus(0, 0);
        applyStimulus(9, 9);
        applyStimulus(5, 0);
        applyStimulus(9, 0);
        applyStimulus(0, 0);
        repeat (30) applyStimulus(1, 0);

        applyStimulus(9, 9);
        applyStimulus(0, 0);
        repeat (8) applyStimulus(2, 1);
        applyStimulus(9, 9);
        applyStimulus(0, 0);
        repeat (6) applyStimulus(2, 1);
        applyReset();
        repeat (12) applyStimulus(2, 1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(9, 9);
                applyStimulus(0, 0);
            end else begin
                applyStimulus(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
            end
        end

        applyReset();
        repeat (2) applyStimulus(3, 2);
        applyStimulus(12, 2);
        repeat (5) applyStimulus(3, 2);
        applyStimulus(4, 11);
        repeat (3) applyStimulus(3, 2);
        applyReset();
        repeat (4) applyStimulus(3, 2);

        monitorEnable = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
